collision_detector: RTL

- Sits directly downstream of the trex character block, consuming its adjusted collision boxes and outer bounding box each game tick.
- Compares them against the active obstacle boxes, one box pair per cycle, in a Chrome-dino style two-level test: outer box first, then inner boxes.
- Owns the lives counter and drives the trex block's crack and crash inputs, which trex samples on its next update.

---
 rtl/collision_pkg.sv | 36 +++
 rtl/box_overlap.sv | 38 +++
 rtl/collision_detector.sv | 193 +++++++++++++++++++
 3 files changed

// File: rtl/collision_pkg.sv
// Shared types for trex collision detection: box record, scan states.
// Also holds default lives and the trex inner box count.
package collision_pkg;

   typedef struct packed {
      logic signed [11:0] x;
      logic signed [11:0] y;
      logic [9:0]         w;
      logic [9:0]         h;
   } collision_box_t;

   localparam int DEFAULT_LIVES       = 2;
   localparam int COLLISION_BOX_COUNT = 6;

   typedef enum logic [1:0] {
      IDLE,
      OUTER,
      INNER,
      DONE
   } detect_state_t;

   // Sign-extend a coordinate to 13 bits so edge sums cannot wrap.
   function automatic logic signed [12:0] ext13(
      input logic signed [11:0] v
   );
      return {v[11], v};
   endfunction

   // Zero-extend a size to a non-negative 13-bit signed value.
   function automatic logic signed [12:0] len13(
      input logic [9:0] v
   );
      return $signed({3'b000, v});
   endfunction

endpackage

// File: rtl/box_overlap.sv
// Combinational axis-aligned overlap test between two collision boxes.
// Ports: a, b boxes in; overlap out (empty boxes never overlap).
module box_overlap
   import collision_pkg::*;
(
   input  collision_box_t a,
   input  collision_box_t b,
   output logic           overlap
);

   logic signed [12:0] ax0;
   logic signed [12:0] ax1;
   logic signed [12:0] ay0;
   logic signed [12:0] ay1;
   logic signed [12:0] bx0;
   logic signed [12:0] bx1;
   logic signed [12:0] by0;
   logic signed [12:0] by1;
   logic               non_empty;

   assign ax0 = ext13(a.x);
   assign ay0 = ext13(a.y);
   assign bx0 = ext13(b.x);
   assign by0 = ext13(b.y);
   assign ax1 = ax0 + len13(a.w);
   assign ay1 = ay0 + len13(a.h);
   assign bx1 = bx0 + len13(b.w);
   assign by1 = by0 + len13(b.h);

   // A zero-sized box would otherwise pass the strict edge tests.
   assign non_empty = (a.w != '0) && (a.h != '0) &&
                      (b.w != '0) && (b.h != '0);

   assign overlap = non_empty &&
                    (ax0 < bx1) && (ax1 > bx0) &&
                    (ay0 < by1) && (ay1 > by0);

endmodule

// File: rtl/collision_detector.sv
// Scans trex boxes against obstacle boxes each tick, one pair per cycle;
// owns lives and drives trex crack/crash.
// Ports: clk, rst (sync, high), start, trex_* geometry, trex_box[],
// immune, obstacle_box[], obstacle_valid -> busy, crack, crash, lives,
// hit_index.
module collision_detector
   import collision_pkg::*;
#(
   parameter int OBSTACLE_COUNT = 3,
   parameter int LIVES          = DEFAULT_LIVES,
   parameter int TREX_BOX_COUNT = COLLISION_BOX_COUNT
) (
   input  logic                      clk,
   input  logic                      rst,
   input  logic                      start,
   input  logic signed [11:0]        trex_x,
   input  logic signed [11:0]        trex_y,
   input  logic [9:0]                trex_width,
   input  logic [9:0]                trex_height,
   input  collision_box_t            trex_box [TREX_BOX_COUNT],
   input  logic                      immune,
   input  collision_box_t            obstacle_box [OBSTACLE_COUNT],
   input  logic [OBSTACLE_COUNT-1:0] obstacle_valid,
   output logic                      busy,
   output logic                      crack,
   output logic                      crash,
   output logic [1:0]                lives,
   output logic [1:0]                hit_index
);

   localparam logic [1:0] LAST_SLOT  = 2'(OBSTACLE_COUNT - 1);
   localparam logic [2:0] LAST_BOX   = 3'(TREX_BOX_COUNT - 1);
   localparam logic [1:0] LIVES_INIT = 2'(LIVES);

   detect_state_t state;
   detect_state_t state_n;

   logic [1:0] slot;
   logic [1:0] slot_n;
   logic [2:0] box;
   logic [2:0] box_n;
   logic       hit_q;
   logic       hit_n;
   logic       crack_n;
   logic       crash_n;
   logic [1:0] lives_n;
   logic [1:0] hit_index_n;
   logic       snap_load;

   logic signed [11:0]        snap_x;
   logic signed [11:0]        snap_y;
   logic [9:0]                snap_w;
   logic [9:0]                snap_h;
   logic                      snap_immune;
   logic [OBSTACLE_COUNT-1:0] snap_valid;
   collision_box_t            snap_trex [TREX_BOX_COUNT];
   collision_box_t            snap_obs  [OBSTACLE_COUNT];

   collision_box_t outer_box;
   collision_box_t cur_obs;
   collision_box_t cur_trex;
   logic           outer_hit;
   logic           inner_hit;

   // Inputs are frozen at start so mid-scan changes cannot mix ticks.
   always_ff @(posedge clk) begin
      if (snap_load) begin
         snap_x      <= trex_x;
         snap_y      <= trex_y;
         snap_w      <= trex_width;
         snap_h      <= trex_height;
         snap_immune <= immune;
         snap_valid  <= obstacle_valid;
         snap_trex   <= trex_box;
         snap_obs    <= obstacle_box;
      end
   end

   // Outer box is inset by one pixel; narrow trex degrades to empty.
   always_comb begin
      outer_box.x = snap_x + 12'sd1;
      outer_box.y = snap_y + 12'sd1;
      outer_box.w = (snap_w >= 10'd2) ? snap_w - 10'd2 : '0;
      outer_box.h = (snap_h >= 10'd2) ? snap_h - 10'd2 : '0;
   end

   assign cur_obs  = snap_obs[slot];
   assign cur_trex = snap_trex[box];

   box_overlap u_outer (
      .a       (outer_box),
      .b       (cur_obs),
      .overlap (outer_hit)
   );

   box_overlap u_inner (
      .a       (cur_trex),
      .b       (cur_obs),
      .overlap (inner_hit)
   );

   always_ff @(posedge clk) begin
      if (rst) begin
         state     <= IDLE;
         slot      <= '0;
         box       <= '0;
         hit_q     <= 1'b0;
         crack     <= 1'b0;
         crash     <= 1'b0;
         lives     <= LIVES_INIT;
         hit_index <= '0;
      end else begin
         state     <= state_n;
         slot      <= slot_n;
         box       <= box_n;
         hit_q     <= hit_n;
         crack     <= crack_n;
         crash     <= crash_n;
         lives     <= lives_n;
         hit_index <= hit_index_n;
      end
   end

   always_comb begin
      state_n     = state;
      slot_n      = slot;
      box_n       = box;
      hit_n       = hit_q;
      crack_n     = crack;
      crash_n     = crash;
      lives_n     = lives;
      hit_index_n = hit_index;
      snap_load   = 1'b0;
      unique case (state)
         IDLE: begin
            if (start) begin
               snap_load = 1'b1;
               slot_n    = '0;
               box_n     = '0;
               hit_n     = 1'b0;
               state_n   = OUTER;
            end
         end
         OUTER: begin
            if (snap_valid[slot] && outer_hit) begin
               box_n   = '0;
               state_n = INNER;
            end else if (slot == LAST_SLOT) begin
               state_n = DONE;
            end else begin
               slot_n = slot + 2'd1;
            end
         end
         INNER: begin
            if (inner_hit) begin
               hit_n   = 1'b1;
               state_n = DONE;
            end else if (box == LAST_BOX) begin
               if (slot == LAST_SLOT) begin
                  state_n = DONE;
               end else begin
                  slot_n  = slot + 2'd1;
                  state_n = OUTER;
               end
            end else begin
               box_n = box + 3'd1;
            end
         end
         DONE: begin
            state_n = IDLE;
            // After a crash the outputs are frozen until reset.
            if (!crash) begin
               if (hit_q && !snap_immune) begin
                  hit_index_n = slot;
                  if (lives != '0) begin
                     crack_n = 1'b1;
                     lives_n = lives - 2'd1;
                  end else begin
                     crack_n = 1'b0;
                     crash_n = 1'b1;
                  end
               end else begin
                  crack_n = 1'b0;
               end
            end
         end
         default: state_n = IDLE;
      endcase
   end

   assign busy = (state != IDLE);

endmodule
